// File: rtl/coin_pkg.sv
// Shared constants and types for the coin input path: channel indices,
// coin type codes and the fixed cent value of each coin.
package coin_pkg;

    localparam int NUM_CH     = 3;
    localparam int CH_NICKEL  = 0;
    localparam int CH_DIME    = 1;
    localparam int CH_QUARTER = 2;

    localparam int VALUE_W = 5;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        NICKEL    = 2'd1,
        DIME      = 2'd2,
        QUARTER   = 2'd3
    } coin_type_t;

    localparam logic [VALUE_W-1:0] VALUE_NICKEL  = 5'd5;
    localparam logic [VALUE_W-1:0] VALUE_DIME    = 5'd10;
    localparam logic [VALUE_W-1:0] VALUE_QUARTER = 5'd25;

    function automatic logic [VALUE_W-1:0] coin_value_of(input coin_type_t t);
        logic [VALUE_W-1:0] v;
        case (t)
            NICKEL:  v = VALUE_NICKEL;
            DIME:    v = VALUE_DIME;
            QUARTER: v = VALUE_QUARTER;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One coin slot: two-flop synchroniser followed by a counting debouncer.
// rise pulses combinationally on the edge where the debounced level goes 0->1.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The change is accepted on the D-th consecutive cycle that differs from db.
    assign flip = (sync2 != db) && (cnt == CNT_LAST);
    assign rise = flip && sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (flip) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces three coin switches and hands one event per press to the vending
// controller over valid/ready, quarter > dime > nickel.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         coin_raw,
    input  logic               coin_ready,
    output logic               coin_valid,
    output logic [1:0]         coin_type,
    output logic [VALUE_W-1:0] coin_value,
    output logic               overrun
);

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] clear;
    coin_type_t        sel_type;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk (clk),
            .rst (rst),
            .raw (coin_raw[i]),
            .rise(rise[i])
        );
    end

    // Decoded from pending only, so outputs hold steady while the controller stalls.
    always_comb begin
        sel      = '0;
        sel_type = COIN_NONE;
        if (pending[CH_QUARTER]) begin
            sel[CH_QUARTER] = 1'b1;
            sel_type        = QUARTER;
        end else if (pending[CH_DIME]) begin
            sel[CH_DIME] = 1'b1;
            sel_type     = DIME;
        end else if (pending[CH_NICKEL]) begin
            sel[CH_NICKEL] = 1'b1;
            sel_type       = NICKEL;
        end
    end

    assign coin_valid = |pending;
    assign coin_type  = sel_type;
    assign coin_value = coin_value_of(sel_type);
    assign clear      = (coin_valid && coin_ready) ? sel : '0;

    // A rise landing on a channel that is being accepted this edge simply re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= (pending & ~clear) | rise;
            overrun <= |(rise & pending & ~clear);
        end
    end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner: constant vector table,
// directed corner sequences and a randomized run against a behavioural model.
module tb_coin_input_conditioner;
    import coin_pkg::*;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   coin_raw;
    logic         coin_ready;
    logic         coin_valid;
    logic [1:0]   coin_type;
    logic [4:0]   coin_value;
    logic         overrun;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: a raw-sample delay line, a window of the last D
    // synchronised samples per channel, and a set of pending channels.
    logic [2:0] dly[$];
    bit         win[3][$];
    bit         m_db[3];
    logic [2:0] m_pending;
    logic       m_overrun;

    typedef struct {
        logic       r;
        logic [2:0] rw;
        logic       rd;
        logic       ev;
        logic [1:0] et;
        logic [4:0] eval;
        logic       eov;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coin_raw  (coin_raw),
        .coin_ready(coin_ready),
        .coin_valid(coin_valid),
        .coin_type (coin_type),
        .coin_value(coin_value),
        .overrun   (overrun)
    );

    function automatic int top_channel(input logic [2:0] p);
        for (int c = 2; c >= 0; c--) if (p[c]) return c;
        return -1;
    endfunction

    function automatic logic [4:0] cents(input int ch);
        int table_c[3] = '{5, 10, 25};
        if (ch < 0) return 5'd0;
        return 5'(table_c[ch]);
    endfunction

    task automatic model_reset();
        dly = '{3'b000, 3'b000};
        for (int c = 0; c < 3; c++) begin
            win[c].delete();
            m_db[c] = 1'b0;
        end
        m_pending = '0;
        m_overrun = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic [2:0] rw, input logic rd);
        logic [2:0] s;
        logic [2:0] rises;
        logic [2:0] clr;
        int         sel;
        bit         all_differ;
        if (r) begin
            model_reset();
            return;
        end
        s = dly.pop_front();
        dly.push_back(rw);
        rises = '0;
        for (int c = 0; c < 3; c++) begin
            win[c].push_back(s[c]);
            if (win[c].size() > D) void'(win[c].pop_front());
            if (win[c].size() == D) begin
                all_differ = 1'b1;
                foreach (win[c][k]) if (win[c][k] == m_db[c]) all_differ = 1'b0;
                if (all_differ) begin
                    m_db[c] = !m_db[c];
                    if (m_db[c]) rises[c] = 1'b1;
                end
            end
        end
        sel = top_channel(m_pending);
        clr = (sel >= 0 && rd) ? 3'(1 << sel) : 3'b000;
        m_overrun = |(rises & m_pending & ~clr);
        m_pending = (m_pending & ~clr) | rises;
    endtask

    task automatic checkOutput(input string name);
        int         sel;
        logic       ev;
        logic [1:0] et;
        logic [4:0] eval;
        sel  = top_channel(m_pending);
        ev   = |m_pending;
        et   = (sel >= 0) ? 2'(sel + 1) : 2'd0;
        eval = cents(sel);
        compared++;
        if (coin_valid !== ev || coin_type !== et || coin_value !== eval || overrun !== m_overrun) begin
            mismatched++;
            $display("[TB] FAIL %s model: got valid=%b type=%0d value=%0d overrun=%b, expected valid=%b type=%0d value=%0d overrun=%b",
                     name, coin_valid, coin_type, coin_value, overrun, ev, et, eval, m_overrun);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] rw, input logic rd, input string name);
        @(negedge clk);
        rst        = r;
        coin_raw   = rw;
        coin_ready = rd;
        @(posedge clk);
        model_edge(r, rw, rd);
        #1;
        checkOutput(name);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 3'b000, 1'b0, "reset");
        applyStimulus(1'b1, 3'b000, 1'b0, "reset");
    endtask

    initial begin
        int         first_idx;
        int         n_valid;
        int         n_over;
        int         n_25;
        logic [2:0] rnd_raw;
        logic       rnd_rd;
        logic       rnd_rst;

        rst        = 1'b1;
        coin_raw   = 3'b000;
        coin_ready = 1'b0;
        model_reset();

        // Vector table: reset with all switches held, then quarter-priority latency.
        for (int k = 0; k < 10; k++) vecs.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0});
        for (int k = 0; k < D + 1; k++) vecs.push_back('{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0});
        for (int k = 0; k < 5; k++) vecs.push_back('{1'b0, 3'b111, 1'b0, 1'b1, 2'd3, 5'd25, 1'b0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].rw, vecs[i].rd, "table");
            compared++;
            if (coin_valid !== vecs[i].ev || coin_type !== vecs[i].et ||
                coin_value !== vecs[i].eval || overrun !== vecs[i].eov) begin
                mismatched++;
                $display("[TB] FAIL vector %0d: got valid=%b type=%0d value=%0d overrun=%b, expected valid=%b type=%0d value=%0d overrun=%b",
                         i, coin_valid, coin_type, coin_value, overrun,
                         vecs[i].ev, vecs[i].et, vecs[i].eval, vecs[i].eov);
            end
        end

        // Single dime with ready high: one event, at the 6th cycle after first sample.
        do_reset();
        first_idx = -1;
        n_valid   = 0;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b0, (k < 10) ? 3'b010 : 3'b000, 1'b1, "dime");
            if (coin_valid === 1'b1) begin
                n_valid++;
                if (first_idx < 0) begin
                    first_idx = k;
                    checkValue("dime_type", int'(coin_type), 2);
                    checkValue("dime_value", int'(coin_value), 10);
                end
            end
        end
        checkValue("dime_event_count", n_valid, 1);
        checkValue("dime_latency", first_idx, D + 1);

        // Bounce shorter than the debounce window never produces an event.
        do_reset();
        n_valid = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, (k < 6) ? {2'b00, 1'(~k[0])} : 3'b000, 1'b1, "bounce");
            if (coin_valid === 1'b1) n_valid++;
        end
        checkValue("bounce_event_count", n_valid, 0);

        // Simultaneous presses drain in priority order with no bubble.
        do_reset();
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, (k < 8) ? 3'b111 : 3'b000, 1'b0, "simul_hold");
        checkValue("simul_hold_valid", int'(coin_valid), 1);
        checkValue("simul_hold_value", int'(coin_value), 25);
        applyStimulus(1'b0, 3'b000, 1'b1, "simul_drain");
        checkValue("simul_second_value", int'(coin_value), 10);
        applyStimulus(1'b0, 3'b000, 1'b1, "simul_drain");
        checkValue("simul_third_value", int'(coin_value), 5);
        applyStimulus(1'b0, 3'b000, 1'b1, "simul_drain");
        checkValue("simul_empty_valid", int'(coin_valid), 0);

        // Second quarter press while the first is still pending.
        do_reset();
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 3'b100, 1'b0, "ovr_press1");
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 3'b000, 1'b0, "ovr_release");
        n_over = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, (k < 6) ? 3'b100 : 3'b000, 1'b0, "ovr_press2");
            if (overrun === 1'b1) n_over++;
        end
        checkValue("overrun_pulse_count", n_over, 1);
        n_25 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            coin_ready = 1'b1;
            if (coin_valid === 1'b1 && coin_value === 5'd25) n_25++;
            applyStimulus(1'b0, 3'b000, 1'b1, "ovr_drain");
        end
        checkValue("overrun_quarter_events", n_25, 1);

        // Reset in the middle of operation drops the pending dime.
        do_reset();
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 3'b010, 1'b0, "mid_press");
        checkValue("mid_pending_valid", int'(coin_valid), 1);
        applyStimulus(1'b1, 3'b000, 1'b0, "mid_reset");
        checkValue("mid_after_reset_valid", int'(coin_valid), 0);
        n_valid = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 3'b000, 1'b1, "mid_idle");
            if (coin_valid === 1'b1) n_valid++;
        end
        checkValue("mid_no_event", n_valid, 0);

        // Randomized run: switches toggle occasionally (some bounces, some holds).
        do_reset();
        rnd_raw = 3'b000;
        rnd_rd  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 3; c++) if ($urandom_range(0, 5) == 0) rnd_raw[c] = ~rnd_raw[c];
            if ($urandom_range(0, 7) == 0) rnd_rd = ~rnd_rd;
            rnd_rst = ($urandom_range(0, 499) == 0);
            applyStimulus(rnd_rst, rnd_raw, rnd_rd, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
